// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: write side of an async FIFO shared by two producers.
// Round-robin arbitration between two requesters, registered RAM write port,
// Gray write pointer generation, full/almost_full flags computed against the
// already-synchronized Gray read pointer, and a sticky Gray-violation detector
// on that synchronized pointer.
//
// Handshake: reqX is a valid, gntX is a combinational ready. A producer holds
// reqX and dataX stable until it sees gntX. One word moves on each rising edge
// where reqX && gntX. gntX never depends on the data, and is low during reset
// and while full.
module fifo_wr_arb #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int AFULL_GAP  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic                  gnt0,
  output logic                  gnt1,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic                  sync_err,
  input  logic                  err_clr
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AFULL_GAP);

  logic [PW-1:0]         wbin;
  logic [PW-1:0]         wbin_next;
  logic [PW-1:0]         wgray_next;
  logic [PW-1:0]         rbin_sync;
  logic [PW-1:0]         fill_next;
  logic [PW-1:0]         full_cmp;
  logic [PW-1:0]         rptr_q;
  logic [PW-1:0]         rptr_diff;
  logic                  rptr_bad;
  logic                  last_gnt;  // 1: requester 1 won the last transfer
  logic                  xfer;
  logic [DATA_WIDTH-1:0] wdata_sel;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Round-robin grant: a lone requester wins, on a tie the one that did not win last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && !full) begin
      if (req0 && req1) begin
        if (last_gnt) gnt0 = 1'b1;
        else          gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Next-pointer and flag arithmetic shared by the registers below.
  always_comb begin
    xfer       = (req0 && gnt0) || (req1 && gnt1);
    wdata_sel  = gnt0 ? data0 : data1;
    wbin_next  = wbin + PW'(xfer);
    wgray_next = wbin_next ^ (wbin_next >> 1);
    rbin_sync  = gray2bin(rptr_gray_sync);
    fill_next  = wbin_next - rbin_sync;
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    full_cmp   = {~rptr_gray_sync[PW-1:PW-2], rptr_gray_sync[PW-3:0]};
    rptr_diff  = rptr_gray_sync ^ rptr_q;
    // More than one bit set: clearing the lowest set bit leaves something behind.
    rptr_bad   = |(rptr_diff & (rptr_diff - PW'(1)));
  end

  // Write pointer and registered RAM write port; address/data hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbin      <= '0;
      wptr_gray <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      wbin      <= wbin_next;
      wptr_gray <= wgray_next;
      mem_we    <= xfer;
      if (xfer) begin
        mem_waddr <= wbin[ADDR_WIDTH-1:0];
        mem_wdata <= wdata_sel;
      end
    end
  end

  // Status flags look at the post-transfer pointer so they never lag a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      full        <= (wgray_next == full_cmp);
      almost_full <= (fill_next >= AF_LEVEL);
    end
  end

  // Arbitration history moves only when a word is actually accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     last_gnt <= 1'b1;
    else if (xfer) last_gnt <= gnt1;
  end

  // Sticky Gray-violation detector; a new violation beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr_q   <= '0;
      sync_err <= 1'b0;
    end else begin
      rptr_q <= rptr_gray_sync;
      if (rptr_bad)     sync_err <= 1'b1;
      else if (err_clr) sync_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Testbench for fifo_wr_arb: directed scenarios plus a randomized run against
// a counter-based reference model; writes are checked through a scoreboard.
module tb_fifo_wr_arb;

  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam int MODN = 1 << (AW + 1);
  localparam int DEP  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [DW-1:0] data0 = '0, data1 = '0;
  logic          gnt0, gnt1;
  logic [AW:0]   rptr_gray_sync = '0;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [AW:0]   wptr_gray;
  logic          full, almost_full, sync_err;
  logic          err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model: write count and read count as plain integers mod 2*DEPTH.
  int   m_wcnt = 0;
  int   m_rd   = 0;
  logic m_win0 = 1'b1;   // requester 0 wins the next tie
  logic m_full = 1'b0;
  logic m_af   = 1'b0;

  logic [AW+DW-1:0] exp_q[$];

  fifo_wr_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_GAP(2)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .rptr_gray_sync(rptr_gray_sync), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .wptr_gray(wptr_gray), .full(full),
    .almost_full(almost_full), .sync_err(sync_err), .err_clr(err_clr)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  function automatic logic [AW:0] gray(input int b);
    int m;
    m = b % MODN;
    return (AW+1)'(m ^ (m >> 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each registered write must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          logic [AW+DW-1:0] e;
          e = exp_q.pop_front();
          check("write_addr_data", {mem_waddr, mem_wdata}, e);
        end
      end else if (exp_q.size() != 0) begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        check("missing_write", 32'd0, {20'd0, e});
      end
    end
  end

  task automatic model_reset();
    m_wcnt = 0;
    m_rd   = 0;
    m_win0 = 1'b1;
    m_full = 1'b0;
    m_af   = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_gnt0"}, gnt0, 0);
    check({tag, "_gnt1"}, gnt1, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_waddr"}, mem_waddr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_wptr_gray"}, wptr_gray, 0);
    check({tag, "_full"}, full, 0);
    check({tag, "_almost_full"}, almost_full, 0);
    check({tag, "_sync_err"}, sync_err, 0);
  endtask

  // Driver: assert reset now (asynchronously), check, release #1 after an edge.
  task automatic apply_reset(input string tag);
    reset = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    err_clr = 1'b0;
    rptr_gray_sync = '0;
    model_reset();
    #1;
    check_reset_values(tag);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  // Driver: one cycle. Called #1 after a rising edge; returns #1 after the next.
  task automatic step(input logic r0, input logic r1, input logic [DW-1:0] d0,
                      input logic [DW-1:0] d1, output logic g0, output logic g1);
    logic             push;
    logic [AW+DW-1:0] ent;
    int               fill;
    req0 = r0;
    req1 = r1;
    data0 = d0;
    data1 = d1;
    rptr_gray_sync = gray(m_rd);
    g0 = 1'b0;
    g1 = 1'b0;
    if (!m_full) begin
      if (r0 && r1) begin
        g0 = m_win0;
        g1 = !m_win0;
      end else begin
        g0 = r0;
        g1 = r1;
      end
    end
    #2;
    check("gnt0", gnt0, g0);
    check("gnt1", gnt1, g1);
    push = g0 || g1;
    ent  = {AW'(m_wcnt % DEP), (g0 ? d0 : d1)};
    if (push) begin
      m_wcnt = (m_wcnt + 1) % MODN;
      m_win0 = g1;
    end
    fill   = (m_wcnt - m_rd + MODN) % MODN;
    m_full = (fill == DEP);
    m_af   = (fill >= DEP - 2);
    @(posedge clk);
    #1;
    if (push) exp_q.push_back(ent);
    check("full", full, m_full);
    check("almost_full", almost_full, m_af);
    check("wptr_gray", wptr_gray, gray(m_wcnt));
  endtask

  logic g0, g1;
  logic p0, p1;
  logic [DW-1:0] pd0, pd1;

  initial begin
    #1;
    apply_reset("reset");

    // Single write from producer 0.
    step(1, 0, 8'hA5, 8'h00, g0, g1);
    check("first_wptr_gray", wptr_gray, 5'b00001);

    // Both requesting from a fresh reset: alternation 0,1,0,1 at addresses 0..3.
    @(posedge clk); #1;
    apply_reset("reset2");
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 8'(8'h10 + i), 8'(8'h20 + i), g0, g1);
      check("rr_order", {31'd0, g1}, 32'(i % 2));
    end

    // Fill to 16 with no reads, then one refused request.
    for (int i = 4; i < 16; i++) begin
      step(1, 0, 8'(i), 8'h00, g0, g1);
      if (i == 13) check("af_after_14", almost_full, 1);
      if (i == 13) check("not_full_at_14", full, 0);
    end
    check("full_after_16", full, 1);
    check("wptr_gray_full", wptr_gray, 5'b11000);
    step(0, 1, 8'h00, 8'h77, g0, g1);
    check("no_grant_when_full", {g0, g1}, 0);

    // One read releases full; the next write wraps to address 0.
    m_rd = 1;
    step(0, 1, 8'h00, 8'h77, g0, g1);
    check("full_released", full, 0);
    step(0, 1, 8'h00, 8'h77, g0, g1);
    check("wrap_grant", g1, 1);
    step(0, 0, 8'h00, 8'h00, g0, g1);

    // Gray violation on the synchronized read pointer.
    @(posedge clk); #1;
    apply_reset("reset3");
    rptr_gray_sync = 5'b00011;
    @(posedge clk); @(posedge clk); #1;
    check("sync_err_set", sync_err, 1);
    @(posedge clk); #1;
    check("sync_err_sticky", sync_err, 1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("sync_err_cleared", sync_err, 0);
    err_clr = 1'b1;
    rptr_gray_sync = 5'b00000;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("sync_err_set_wins", sync_err, 1);

    // Randomized traffic with a read side that first lags, then keeps up.
    @(posedge clk); #1;
    apply_reset("reset4");
    p0 = 0; p1 = 0; pd0 = '0; pd1 = '0;
    for (int i = 0; i < 600; i++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin p0 = 1; pd0 = DW'($urandom); end
      if (!p1 && $urandom_range(0, 2) != 0) begin p1 = 1; pd1 = DW'($urandom); end
      if (m_rd != m_wcnt && ((i < 250) ? ($urandom_range(0, 7) == 0)
                                        : ($urandom_range(0, 1) == 0)))
        m_rd = (m_rd + 1) % MODN;
      step(p0, p1, pd0, pd1, g0, g1);
      if (g0) p0 = 0;
      if (g1) p1 = 0;
    end
    check("no_sync_err_in_traffic", sync_err, 0);

    // Reset in the middle of a transfer cycle with both requesting.
    m_rd = m_wcnt;
    rptr_gray_sync = gray(m_rd);
    req0 = 1'b1; req1 = 1'b1;
    @(posedge clk); #3;
    apply_reset("midstream");
    step(1, 1, 8'h5A, 8'hC3, g0, g1);
    check("first_after_reset_is_0", g0, 1);
    step(0, 0, 8'h00, 8'h00, g0, g1);
    step(0, 0, 8'h00, 8'h00, g0, g1);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: FIFO depth is 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
REQ-002 Parameter DATA_WIDTH, default 8: write data width.
REQ-003 Parameter AFULL_GAP, default 2: almost_full asserts when free slots <= AFULL_GAP.
REQ-004 clk  input  1  write-domain clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req0, req1  input  1  producer write requests; held with data until granted.
REQ-007 data0, data1  input  DATA_WIDTH  producer write data.
REQ-008 gnt0, gnt1  output  1  combinational accept; a transfer occurs on an edge where reqX && gntX.
REQ-009 rptr_gray_sync  input  ADDR_WIDTH+1  Gray read pointer, already passed through the 2-flop pointer synchronizer.
REQ-010 mem_we  output  1  registered write enable to the FIFO RAM.
REQ-011 mem_waddr  output  ADDR_WIDTH  registered RAM write address.
REQ-012 mem_wdata  output  DATA_WIDTH  registered RAM write data.
REQ-013 wptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
REQ-014 full, almost_full  output  1  registered status flags.
REQ-015 sync_err  output  1  sticky Gray-violation flag; err_clr  input  1  clears it.

Function
REQ-016 Internal binary write pointer wbin (ADDR_WIDTH+1 bits) wraps modulo 2**(ADDR_WIDTH+1); wptr_gray = wbin ^ (wbin >> 1), registered.
REQ-017 gnt0/gnt1 are combinational from req0, req1, full and last_gnt; at most one is high; both are low while full=1.
REQ-018 Single requester, not full: that requester is granted.
REQ-019 Both requesting, not full: grant the requester not in last_gnt (round-robin); last_gnt updates only on a transfer.
REQ-020 On a transfer edge: mem_we<=1, mem_waddr<=wbin[ADDR_WIDTH-1:0], mem_wdata<=granted data, wbin<=wbin+1; otherwise mem_we<=0, and mem_waddr/mem_wdata hold.
REQ-021 Latency: a transfer in cycle N gives mem_we=1 in cycle N+1, and wptr_gray reflects the increment in cycle N+1.
REQ-022 full is registered from the next pointer: full <= (gray(wbin_next) == {~rptr_gray_sync[MSB:MSB-1], rptr_gray_sync[MSB-2:0]}).
REQ-023 rbin_sync = Gray-to-binary(rptr_gray_sync); almost_full <= ((wbin_next - rbin_sync) mod 2**(ADDR_WIDTH+1)) >= 2**ADDR_WIDTH - AFULL_GAP.
REQ-024 Flags deassert only via rptr_gray_sync advance; they deassert at most one cycle after the synchronized pointer changes.
REQ-025 rptr_gray_sync is registered once internally; sync_err is set when the current and previous values differ in more than one bit.
REQ-026 sync_err stays set until err_clr=1; if set and clear occur in the same cycle, set wins.
REQ-027 Full with a pending request: no grant and no pointer change; the request stays pending until full deasserts.
REQ-028 Pointer wrap from 2**(ADDR_WIDTH+1)-1 to 0 is silent; flags stay correct across the wrap.

Reset
REQ-029 While reset=1, asynchronously: wbin=0, wptr_gray=0, mem_we=0, mem_waddr=0, mem_wdata=0, full=0, almost_full=0, sync_err=0, last_gnt=1 (req0 wins first), internal rptr register=0.
REQ-030 Reset during a transfer discards it; there is no write pulse after reset release unless a new transfer occurs.
REQ-031 Gnt outputs are 0 while reset=1.

Verification
REQ-032 After reset, req0=1 with data0=0xA5 for one cycle, rptr_gray_sync=0 -> gnt0=1 that cycle; next cycle mem_we=1, mem_waddr=0, mem_wdata=0xA5, wptr_gray=1.
REQ-033 req0=req1=1 held for 4 transfers (ADDR_WIDTH=4) -> grants go 0,1,0,1 and mem_waddr goes 0,1,2,3.
REQ-034 16 writes with rptr_gray_sync=0 -> almost_full=1 after the 14th write; full=1 after the 16th write with wptr_gray=5'b11000; a 17th request gets no grant and no mem_we.
REQ-035 From full, set rptr_gray_sync to 5'b00001 -> full=0 within 1 cycle; the next request is granted and mem_waddr=0 (wrap).
REQ-036 rptr_gray_sync jumps 00000 to 00011 -> sync_err=1 two cycles later and stays 1; pulse err_clr -> sync_err=0.
REQ-037 Assert reset mid-stream with req1=1 -> all outputs reach the REQ-029 values immediately; after release the first grant goes to req0 if both are requesting.
